aes_inv_addroundkey: RTL
========================

Name: aes_inv_addroundkey

Overview:
- Inverse-cipher AddRoundKey stage, directly downstream of the inverse SubBytes stage in the AES decryption datapath.
- Holds a round-key store of NR+1 entries written by the key-expansion logic.
- XORs each accepted 128-bit state with the key for the current round. Tracks the round count down from NR to 0 and flags the final round.
- Uses a valid/ready handshake on both sides with a registered output, so it can stall the upstream stage.

Parameters:
- NR, 10, number of AES rounds (10/12/14); key store depth is NR+1, legal range 10..14.
- RW, 4, width of round index / key address.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- key_we  input  1  round-key write strobe
- key_waddr  input  RW  round-key index, 0..NR
- key_wdata  input  128  round-key value
- restart  input  1  synchronous: reload round counter to NR (abandon block)
- in_valid  input  1  upstream state valid
- in_data  input  128  state from inverse SubBytes
- in_ready  output  1  stage can accept in_data this cycle
- out_valid  output  1  out_data valid
- out_data  output  128  in_data XOR key[round]
- out_round  output  RW  round index used for out_data
- out_last  output  1  out_data used key[0] (block complete)
- out_ready  input  1  downstream accepts out_data

Behaviour:
- Clock is clk; reset is reset_n, asynchronous and active-low. On reset_n low:
  - out_valid=0, out_data=0, out_round=0, out_last=0.
  - Round counter is set to NR.
  - Key store contents are not reset; they are undefined until written.
- Accept: a beat is taken when in_valid && in_ready.
  - Without the optional feature, in_ready = !out_valid || out_ready (combinational).
- Latency: 1 cycle. On accept, the output register loads:
  - out_data = in_data ^ key[cnt]
  - out_round = cnt
  - out_last = (cnt==0)
  - out_valid = 1
- Output hold: while out_valid && !out_ready, out_data, out_round and out_last hold stable.
- Output clear: out_valid clears when out_ready is high and no new beat is accepted in the same cycle.
- Round counter, one state per round value NR..0:
  - Each accepted beat decrements cnt.
  - An accept at cnt==0 reloads cnt to NR. Wrap-around is never to 2^RW-1.
- restart:
  - restart=1 with no accept: cnt <= NR.
  - restart=1 with an accept in the same cycle: restart wins first. The beat uses key[NR] and cnt <= NR-1.
  - restart does not touch the output register.
- Key writes:
  - A write with key_waddr > NR is ignored.
  - A write to the entry read by the same-cycle accept: the accept uses the old key (read-before-write); the new key is visible from the next cycle.
  - Writes are legal at any time, including mid-block.
- Reset asserted mid-block: the in-flight output is dropped (out_valid=0) and cnt returns to NR. The next block starts with key[NR].
- Arithmetic: plain 128-bit bitwise XOR, no carries. Byte order is [127:120] = state byte 0, consistent with the other AES stages.

Optional Feature:
- Macro name: AES_ARK_SKID_EN.
- Defined:
  - A 2-entry skid buffer sits behind the output register.
  - in_ready becomes a registered signal, equal to !skid_full.
  - Upstream beats arriving in the cycle out_ready drops are held in the skid buffer. Order is preserved and there is no loss or duplication.
  - Latency is still 1 cycle when not stalled.
- Undefined:
  - No skid buffer.
  - in_ready is combinational as above.

Test Plan:
- FIPS-197 C.1 vector: write key[10]=13111d7fe3944a17f307a78b4d2b30c5, reset, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> next cycle out_data=7ad5fda789ef4e272bca100b3d9ff59f, out_round=10, out_last=0.
- Full block: key[i]=i replicated across bytes, 11 back-to-back beats of all-zeros with out_ready=1 -> out_round sequence 10..0, out_last only on the 11th beat, the 12th beat uses key[10] again.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> out_data stable, exactly one beat consumed (without AES_ARK_SKID_EN) or three beats in total (with the macro), no beat lost or duplicated after release.
- restart at cnt=4 together with an accept -> that beat uses key[10], out_round=10, the following beat uses key[9].
- Write collision: key_we to key[10]=ffff...ff in the same cycle as an accept at cnt=10 with key[10] previously 0 and in_data=0 -> out_data=0. The next block's first beat gives out_data=ffff...ff.
- Async reset asserted between clock edges mid-block -> out_valid=0 immediately. After release, in_data=0 yields out_data=key[10], out_round=10. A write to key_waddr=15 leaves all keys unchanged.

Source files
------------

// File: rtl/aes_inv_addroundkey.sv
// Inverse-cipher AddRoundKey stage: XORs each accepted 128-bit state with the
// round key for the current round, counting rounds down from NR to 0.
// Byte order: [127:120] is state byte 0.
// Optional feature macro: AES_ARK_SKID_EN (2-entry skid buffer, registered in_ready).
module aes_inv_addroundkey #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          key_we,
  input  logic [RW-1:0] key_waddr,
  input  logic [127:0]  key_wdata,
  input  logic          restart,
  input  logic          in_valid,
  input  logic [127:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [127:0]  out_data,
  output logic [RW-1:0] out_round,
  output logic          out_last,
  input  logic          out_ready
);

  typedef struct packed {
    logic [127:0]  data;
    logic [RW-1:0] round;
    logic          last;
  } beat_t;

  localparam logic [RW-1:0] NR_L = RW'(NR);

  logic [127:0]  keys [0:NR];
  logic [RW-1:0] cnt;
  logic [RW-1:0] cnt_eff;
  logic          accept;
  beat_t         beat;

  // restart takes effect before a same-cycle accept
  assign cnt_eff = restart ? NR_L : cnt;
  assign accept  = in_valid && in_ready;

  // Result of the beat being accepted this cycle (reads the pre-write key)
  always_comb begin
    beat.data  = in_data ^ keys[cnt_eff];
    beat.round = cnt_eff;
    beat.last  = (cnt_eff == '0);
  end

  // Round-key store, not reset; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (key_we && (key_waddr <= NR_L))
      keys[key_waddr] <= key_wdata;
  end

  // Round counter: NR down to 0, then back to NR on the final beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= NR_L;
    else if (accept)
      cnt <= (cnt_eff == '0) ? NR_L : cnt_eff - 1'b1;
    else if (restart)
      cnt <= NR_L;
  end

`ifdef AES_ARK_SKID_EN
  beat_t       skid [2];
  logic [1:0]  skid_cnt;
  logic [1:0]  skid_nxt;
  logic        load_out;

  // Output register may take a new value when empty or being drained
  assign load_out = !out_valid || out_ready;

  // Next skid occupancy; in_ready is low whenever both slots hold beats
  always_comb begin
    skid_nxt = skid_cnt;
    if (load_out) begin
      if ((skid_cnt != 2'd0) && !accept)
        skid_nxt = skid_cnt - 2'd1;
    end else if (accept) begin
      skid_nxt = skid_cnt + 2'd1;
    end
  end

  // Output register fed from the skid head first, so order is preserved
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
      skid[0]   <= '0;
      skid[1]   <= '0;
      skid_cnt  <= 2'd0;
      in_ready  <= 1'b1;
    end else begin
      if (load_out) begin
        if (skid_cnt != 2'd0) begin
          {out_data, out_round, out_last} <= skid[0];
          out_valid <= 1'b1;
          if (skid_cnt == 2'd2)
            skid[0] <= skid[1];
          else if (accept)
            skid[0] <= beat;
        end else if (accept) begin
          {out_data, out_round, out_last} <= beat;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid[skid_cnt[0]] <= beat;
      end
      skid_cnt <= skid_nxt;
      in_ready <= (skid_nxt != 2'd2);
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  // Single output register: load on accept, hold on stall, clear on drain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      {out_data, out_round, out_last} <= beat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
